move_input_conditioner: RTL
===========================

MOVE_INPUT_CONDITIONER -- requirements
Module: move_input_conditioner

Interface
REQ-001 Parameter SHALL be: N_DEBOUNCE, default 500000, number of consecutive stable synchronized samples needed to accept a press or release; legal range 2 to 2^24-1.
REQ-002 Clk  input  1  sole clock; all state SHALL change only on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 btnU, btnD, btnL, btnR  input  1 each  raw asynchronous push-buttons, active-high.
REQ-005 arm  input  1  high while the game FSM accepts moves; low in init, win and lose.
REQ-006 move_ack  input  1  consumer has taken the current move.
REQ-007 move_valid  output  1  a move is held.
REQ-008 move_dir  output  2  held direction code.
REQ-009 up, down, left, right  output  1 each  one-hot decode of move_dir, gated by move_valid.
REQ-010 overrun  output  1  single-cycle pulse when a press is discarded.

Function
REQ-011 Each btn SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Each synchronized button SHALL drive one debouncer FSM with states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE, plus a counter sized by $clog2(N_DEBOUNCE).
REQ-013 Debouncer transitions SHALL be:
- IDLE: s=1 -> WAIT_PRESS, counter cleared.
- WAIT_PRESS: s=0 -> IDLE; counter=N_DEBOUNCE-1 -> PRESSED; otherwise counter+1.
- PRESSED: s=0 -> WAIT_RELEASE, counter cleared.
- WAIT_RELEASE: s=1 -> PRESSED; counter=N_DEBOUNCE-1 -> IDLE; otherwise counter+1.
REQ-014 The debouncer SHALL emit a registered press pulse for exactly one cycle on each WAIT_PRESS->PRESSED transition; it SHALL NOT pulse on a WAIT_RELEASE->PRESSED transition.
REQ-015 Any bounce shorter than N_DEBOUNCE samples SHALL produce no pulse, and a held button SHALL produce exactly one pulse.
REQ-016 The command FSM SHALL have two states, EMPTY and HOLD; move_valid=1 exactly in HOLD.
REQ-017 In EMPTY with arm=1 and at least one press pulse, the FSM SHALL capture the highest-priority direction (up > down > left > right) and enter HOLD on the next edge.
REQ-018 Simultaneous pulses SHALL resolve by the REQ-017 priority, and each losing pulse SHALL raise overrun for that cycle.
REQ-019 In HOLD, move_dir SHALL stay stable, and move_ack=1 SHALL return the FSM to EMPTY so that move_valid is low in the following cycle.
REQ-020 Any press pulse arriving in HOLD, including in the cycle that move_ack is high, SHALL be discarded and SHALL pulse overrun.
REQ-021 Press pulses arriving while arm=0 SHALL be discarded silently, with no overrun.
REQ-022 arm falling while in HOLD SHALL NOT cancel the held move.
REQ-023 With a clean press, move_valid SHALL first be high after the (N_DEBOUNCE+4)th rising edge, counted from the first edge that samples btn high.
REQ-024 up, down, left and right SHALL be combinational decodes of the registered move_valid and move_dir.

Reset
REQ-025 Reset=1 at an edge SHALL clear the synchronizers to 0, every debouncer to IDLE with counter 0, and the command FSM to EMPTY, with move_dir=0.
REQ-026 During and after reset, move_valid, up, down, left, right and overrun SHALL all be 0.
REQ-027 Reset asserted mid-debounce or mid-HOLD SHALL abort the operation with no pulse and no held move.
REQ-028 A button still held when Reset is released SHALL re-qualify from IDLE.

Structure
REQ-029 The shared package ee354_2048_pkg SHALL hold the direction codes (UP=2'd0, DOWN=2'd1, LEFT=2'd2, RIGHT=2'd3), the debouncer and command state encodings, and the N_DEBOUNCE default.
REQ-030 The design SHALL contain one sub-module, button_debounce (synchronizer + debouncer FSM + counter + pulse), instantiated four times.
REQ-031 The block SHALL contain no latches and no clock gating.

Verification (N_DEBOUNCE=4)
REQ-032 Clean btnU press held 20 cycles -> move_valid=1 and up=1 after edge 8, held until move_ack, with one move only.
REQ-033 btnL toggling every 2 cycles for 12 cycles, then low -> move_valid stays 0 and overrun stays 0.
REQ-034 btnD and btnR pulses in the same cycle while EMPTY -> move_dir=1 (DOWN) and a one-cycle overrun.
REQ-035 In HOLD(UP), a new btnR press before move_ack -> overrun pulses once; after ack, move_valid=0 and no RIGHT move appears.
REQ-036 arm=0 during a btnD press -> no move_valid and no overrun; setting arm=1 later with the button still held -> no move.
REQ-037 Reset asserted in HOLD and mid-WAIT_PRESS -> all outputs 0 on the next cycle, and the held button re-qualifies 8 edges after reset is released.

Source files
------------

// File: rtl/ee354_2048_pkg.sv
// Shared types for the 2048 move path: direction codes,
// debouncer and command FSM encodings, debounce default.
package ee354_2048_pkg;

  localparam int unsigned N_DEBOUNCE_DEFAULT = 500000;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_WAIT_PRESS   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_WAIT_RELEASE = 2'd3
  } db_state_e;

  typedef enum logic {
    CMD_EMPTY = 1'b0,
    CMD_HOLD  = 1'b1
  } cmd_state_e;

  // Bit index of the press vector equals the direction code,
  // so the lowest set bit is the winner.
  function automatic dir_e pick_dir(input logic [3:0] p);
    dir_e d;
    d = RIGHT;
    if (p[0])
      d = UP;
    else if (p[1])
      d = DOWN;
    else if (p[2])
      d = LEFT;
    return d;
  endfunction

  function automatic logic multi_press(input logic [3:0] p);
    return (p & (p - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/move_input_conditioner_debounce.sv
// One push-button: two-flop synchronizer, debounce FSM,
// stability counter and single-cycle press pulse.
module button_debounce
  import ee354_2048_pkg::*;
#(
  parameter int unsigned N_DEBOUNCE = N_DEBOUNCE_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(N_DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DEBOUNCE - 1);

  logic [1:0]    sync;
  logic          s;
  db_state_e     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset)
      sync <= 2'b00;
    else
      sync <= {sync[0], btn};
  end

  assign s = sync[1];

  // A bounce back to 1 during release returns to PRESSED
  // without a pulse, so a held key fires only once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= DB_IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      unique case (state)
        DB_IDLE: begin
          if (s) begin
            state <= DB_WAIT_PRESS;
            cnt   <= '0;
          end
        end
        DB_WAIT_PRESS: begin
          if (!s) begin
            state <= DB_IDLE;
          end else if (cnt == CNT_MAX) begin
            state <= DB_PRESSED;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DB_PRESSED: begin
          if (!s) begin
            state <= DB_WAIT_RELEASE;
            cnt   <= '0;
          end
        end
        DB_WAIT_RELEASE: begin
          if (s) begin
            state <= DB_PRESSED;
          end else if (cnt == CNT_MAX) begin
            state <= DB_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/move_input_conditioner.sv
// Turns four raw buttons into one held move with
// priority resolution, ack handshake and overrun pulse.
module move_input_conditioner
  import ee354_2048_pkg::*;
#(
  parameter int unsigned N_DEBOUNCE = N_DEBOUNCE_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       arm,
  input  logic       move_ack,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       overrun
);

  logic [3:0] btn;
  logic [3:0] pr;
  cmd_state_e state;
  dir_e       dir_q;
  logic       ov_q;

  assign btn = {btnR, btnL, btnD, btnU};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .N_DEBOUNCE(N_DEBOUNCE)
    ) u_db (
      .Clk  (Clk),
      .Reset(Reset),
      .btn  (btn[i]),
      .press(pr[i])
    );
  end

  // Disarmed presses vanish silently, even while holding.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= CMD_EMPTY;
      dir_q <= UP;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      unique case (state)
        CMD_EMPTY: begin
          if (arm && (pr != 4'd0)) begin
            state <= CMD_HOLD;
            dir_q <= pick_dir(pr);
            ov_q  <= multi_press(pr);
          end
        end
        CMD_HOLD: begin
          ov_q <= arm && (pr != 4'd0);
          if (move_ack)
            state <= CMD_EMPTY;
        end
        default: state <= CMD_EMPTY;
      endcase
    end
  end

  assign move_valid = (state == CMD_HOLD);
  assign move_dir   = dir_q;
  assign overrun    = ov_q;

  assign up    = move_valid && (dir_q == UP);
  assign down  = move_valid && (dir_q == DOWN);
  assign left  = move_valid && (dir_q == LEFT);
  assign right = move_valid && (dir_q == RIGHT);

endmodule
